// File: rtl/truth_table_extractor.sv
// Sweeps an N-input combinational function through all 2^N vectors in ascending order,
// captures its truth table and ones-count, and compares the table against EXPECT.
module truth_table_extractor #(
  parameter int unsigned         N      = 4,
  parameter int unsigned         SETTLE = 1,
  parameter logic [(1<<N)-1:0]   EXPECT = 16'h7F77
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N-1:0]      vec,
  input  logic              f_in,
  output logic              busy,
  output logic              done,
  output logic [(1<<N)-1:0] table_out,
  output logic [N:0]        ones,
  output logic              match
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                last;
  logic [(1<<N)-1:0]   tbl_nxt;

  assign last = (vec == '1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = HOLD;
      HOLD:    if (cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last ? DONE : HOLD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == HOLD) || (state == SAMPLE);
    done = (state == DONE);
  end

  always_comb begin
    tbl_nxt      = table_out;
    tbl_nxt[vec] = f_in;
  end

  // match is resolved on the final SAMPLE edge so it is already valid during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      cnt       <= '0;
      table_out <= '0;
      ones      <= '0;
      match     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            cnt       <= 4'(SETTLE);
            table_out <= '0;
            ones      <= '0;
            match     <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt != '0) cnt <= cnt - 4'd1;
        end
        SAMPLE: begin
          table_out <= tbl_nxt;
          ones      <= ones + (N+1)'(f_in);
          if (!last) begin
            vec <= vec + N'(1);
            cnt <= 4'(SETTLE);
          end else begin
            match <= (tbl_nxt == EXPECT);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_extractor.sv
// Scoreboard bench: stimulus pushes expected sweep results, a negedge monitor pops and
// compares them on every done pulse and checks vector pacing against cycle arithmetic.
module tb_truth_table_extractor;

  localparam int S0  = 1;
  localparam int S1  = 0;
  localparam int L0  = 16 * (S0 + 2);
  localparam int L1  = 16 * (S1 + 2);
  localparam logic [15:0] EXP = 16'h7F77;

  typedef struct {
    logic [15:0] tbl;
    int          ones;
    logic        m;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [3:0]  vec0, vec1;
  logic        f_in0, f_in1;
  logic        busy0, busy1, done0, done1, match0, match1;
  logic [15:0] table0, table1;
  logic [4:0]  ones0, ones1;

  logic [15:0] func0, func1;
  logic        noise;
  int          ecnt = 0;
  int          sw_start = -1;
  int          rel0, mrel;
  logic        hold0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$], q1[$];
  exp_t        e0, e1, last0;

  truth_table_extractor #(.N(4), .SETTLE(S0), .EXPECT(EXP)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec(vec0), .f_in(f_in0), .busy(busy0),
    .done(done0), .table_out(table0), .ones(ones0), .match(match0)
  );

  truth_table_extractor #(.N(4), .SETTLE(S1), .EXPECT(EXP)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec(vec1), .f_in(f_in1), .busy(busy1),
    .done(done1), .table_out(table1), .ones(ones1), .match(match1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ecnt  <= ecnt + 1;
    noise <= 1'($urandom);
  end

  // Garbage on f_in outside the sample cycle of each vector must never reach the table.
  always_comb begin
    rel0  = ecnt - sw_start;
    hold0 = (sw_start >= 0) && (rel0 >= 1) && (rel0 <= L0) && (((rel0 - 1) % (S0 + 2)) != S0 + 1);
    f_in0 = hold0 ? noise : func0[vec0];
    f_in1 = func1[vec1];
  end

  task automatic chk(input string nm, input longint act, input longint ex);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  function automatic int popc(input logic [15:0] t);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(t[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sw_start >= 0) begin
        mrel = ecnt - sw_start;
        if (mrel >= 1 && mrel <= L0) begin
          chk("busy0_sweep", busy0, 1);
          chk("vec0_pacing", vec0, (mrel - 1) / (S0 + 2));
          chk("match0_sweep", match0, 0);
          chk("done0_early", done0, 0);
        end
      end
      if (done0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL done0_unexpected: got done=1 expected no pulse (t=%0t)", $time);
        end else begin
          e0 = q0.pop_front();
          chk("done0_cycle", ecnt, e0.cyc);
          chk("table0", table0, e0.tbl);
          chk("ones0", ones0, e0.ones);
          chk("match0", match0, e0.m);
          chk("busy0_at_done", busy0, 0);
        end
      end
      if (done1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL done1_unexpected: got done=1 expected no pulse (t=%0t)", $time);
        end else begin
          e1 = q1.pop_front();
          chk("done1_cycle", ecnt, e1.cyc);
          chk("table1", table1, e1.tbl);
          chk("ones1", ones1, e1.ones);
          chk("match1", match1, e1.m);
        end
      end
    end
  end

  task automatic wait_q0(input int budget);
    int n = 0;
    while (q0.size() != 0 && n < budget) begin tick(); n++; end
    if (q0.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout0: got %0d pending sweeps expected 0", q0.size());
      q0.delete();
    end
  endtask

  task automatic wait_q1(input int budget);
    int n = 0;
    while (q1.size() != 0 && n < budget) begin tick(); n++; end
    if (q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout1: got %0d pending sweeps expected 0", q1.size());
      q1.delete();
    end
  endtask

  task automatic run_sweep0(input logic [15:0] t, input bit extra);
    int x;
    func0 = t;
    x = ecnt;
    last0 = '{t, popc(t), (t == EXP), x + L0 + 1};
    q0.push_back(last0);
    sw_start = x;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    if (extra) begin
      repeat (4) tick();
      start0 = 1'b1; tick(); start0 = 1'b0;
      repeat (14) tick();
      start0 = 1'b1; tick(); start0 = 1'b0;
    end
    wait_q0(L0 + 20);
    repeat (3) tick();
    chk("table0_held", table0, last0.tbl);
    chk("ones0_held", ones0, last0.ones);
    chk("match0_held", match0, last0.m);
    chk("busy0_idle", busy0, 0);
    sw_start = -1;
  endtask

  task automatic run_cont1(input logic [15:0] t);
    int x;
    func1 = t;
    x = ecnt;
    q1.push_back('{t, popc(t), (t == EXP), x + L1 + 1});
    q1.push_back('{t, popc(t), (t == EXP), x + 2 * (L1 + 1) + 1});
    start1 = 1'b1;
    repeat (2 * (L1 + 1) + 1) tick();
    start1 = 1'b0;
    wait_q1(20);
    repeat (L1 + 5) tick();
    chk("busy1_stopped", busy1, 0);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    func0 = '0; func1 = '0;
    tick(); tick();
    chk("rst_vec0", vec0, 0);     chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);   chk("rst_table0", table0, 0);
    chk("rst_ones0", ones0, 0);   chk("rst_match0", match0, 0);
    chk("rst_vec1", vec1, 0);     chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    repeat (10) begin
      tick();
      chk("idle_vec0", vec0, 0);
      chk("idle_busy0", busy0, 0);
    end

    run_sweep0(EXP, 1'b0);
    run_sweep0(16'hFFFF, 1'b0);
    run_sweep0(EXP, 1'b1);

    func0 = EXP;
    last0 = '{EXP, popc(EXP), 1'b1, ecnt + L0 + 1};
    q0.push_back(last0);
    sw_start = ecnt;
    start0 = 1'b1; tick(); start0 = 1'b0;
    repeat (24) tick();
    chk("vec0_before_abort", vec0, 8);
    rst = 1'b1;
    q0.delete();
    sw_start = -1;
    tick();
    chk("abort_vec0", vec0, 0);     chk("abort_busy0", busy0, 0);
    chk("abort_table0", table0, 0); chk("abort_ones0", ones0, 0);
    chk("abort_match0", match0, 0);
    rst = 1'b0;
    repeat (60) tick();
    run_sweep0(EXP, 1'b0);

    for (int k = 0; k < 4; k++) run_sweep0(16'($urandom), 1'b0);

    run_cont1(16'h0000);
    run_cont1(16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
- Sequential sweeper that drives an N-input combinational function under test, such as a 4-input UDP, with every input vector 0..2^N-1 in ascending order.
- Samples the single-bit response for each vector and assembles the complete truth table.
- Reports the ones-count and compares the table against an expected constant.
- Sits between a controller and any combinational primitive; it replaces hand-written vector sequences in testbenches and in on-chip self-check.

Parameters:
- N, 4, number of function inputs; legal range 1..6.
- SETTLE, 1, extra hold cycles per vector before sampling; legal range 0..15.
- EXPECT, 16'h7F77, expected truth table, bit i = f(i); width 2^N. The default is the team's 4-input UDP: zeros at {a,b,c,d} = 3, 7, 15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- vec  output  N  vector to the function under test; MSB = first input (a)
- f_in  input  1  function response
- busy  output  1  high from the cycle after start is accepted until done asserts
- done  output  1  one-cycle pulse when the table is final
- table_out  output  2^N  captured truth table; bit i = response to vec = i
- ones  output  N+1  number of 1 bits in table_out
- match  output  1  table_out == EXPECT; valid when done pulses, held afterwards

Behaviour:
- Reset: every output is set on the first rising edge with rst = 1, regardless of state.
  - vec = 0, busy = 0, done = 0, table_out = 0, ones = 0, match = 0.
  - State = IDLE, hold counter = 0.
- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE, start = 1: next edge clears table_out and ones, sets vec = 0, busy = 1, hold counter = SETTLE, and goes to HOLD.
- HOLD: vec is stable.
  - If the hold counter is nonzero, decrement it.
  - If the counter is 0, go to SAMPLE.
- SAMPLE: on this edge, write table_out[vec] = f_in and add f_in to ones.
  - If vec != 2^N-1: vec increments, hold counter reloads to SETTLE, go to HOLD.
  - Otherwise: go to DONE; vec holds at 2^N-1.
- DONE: lasts one cycle.
  - done = 1, busy = 0, match = (table_out == EXPECT), then go to IDLE.
  - The last table bit is written on the SAMPLE edge, so table_out is final while done is high.
- Latency:
  - Each vector occupies SETTLE+1 HOLD cycles plus 1 SAMPLE cycle.
  - start is accepted at edge 0; done is high during cycle 2^N*(SETTLE+2)+1.
  - For N=4, SETTLE=1 that is cycle 49.
- Holding values:
  - table_out, ones and match hold their last values in IDLE until the next accepted start.
  - match is 0 during a sweep.
- start while not in IDLE is ignored; it does not restart or extend the sweep.
- start held high continuously: a new sweep begins on the edge after DONE. Back-to-back sweeps have exactly one IDLE cycle between them.
- Wrap-around: vec never wraps to 0 inside a sweep. ones never overflows, because its N+1 bits hold 2^N.
- rst mid-sweep aborts immediately to the reset values. No done pulse is produced and the partial table is discarded.
- f_in is sampled only on SAMPLE edges. Changes during HOLD have no effect.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles -> all outputs 0, state IDLE, and vec stays 0 for 10 further cycles with start = 0.
- Golden sweep: N=4, SETTLE=1, f_in driven by the 4-input UDP (f = 0 only for vec 3, 7, 15), start pulsed once.
  - vec steps 0..15, each held 3 cycles.
  - done pulses at cycle 49; table_out = 16'h7F77, ones = 13, match = 1.
- Mismatch: same sweep with f_in forced to 1 -> table_out = 16'hFFFF, ones = 16, match = 0.
- start while busy: pulse start at cycles 5 and 20 of a sweep -> done is still exactly at cycle 49 and only one done pulse occurs.
- Reset mid-sweep: assert rst at cycle 25 (vec = 8) -> next edge gives vec = 0, busy = 0, table_out = 0, and no done pulse; a following start then completes normally with match = 1.
- Zero settle, continuous start: SETTLE = 0, f_in = 0, start tied high.
  - Each vector lasts 2 cycles; done pulses at cycles 33 and 67.
  - Each done shows table_out = 0, ones = 0, match = 0.
